palm_locator: RTL and testbench
===============================

# palm_locator

Parametrised, frame-aware palm locator for the gesture-recognition pipeline. It sits after segmentation and consumes a raster stream of 1-bit object pixels. In each frame it finds the first horizontal run of object pixels at least `MIN_RUN` wide and reports that run's endpoints, its width and the derived palm height. It re-arms on every start-of-frame and reports explicitly when a frame contains no palm.

## Interface
- `IMG_W`, 120, pixels per row
- `IMG_H`, 160, rows per frame
- `CW`, 8, width of coordinate/size outputs; must satisfy `IMG_W`, `IMG_H` ≤ 2^CW
- `MIN_RUN`, 18, minimum qualifying run width in pixels (≥1, ≤ `IMG_W`)
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `pix_valid`  in  1  a pixel is presented this cycle
- `pix`  in  1  object pixel (1 = hand)
- `sof`  in  1  first pixel of frame; qualified by `pix_valid`
- `test_mode`  in  1  selects test height (only with `PALM_HEIGHT_OVERRIDE_EN`)
- `palm_height_test`  in  CW  test palm height (only with `PALM_HEIGHT_OVERRIDE_EN`)
- `start_r`, `start_c`, `end_r`, `end_c`  out  CW each  row/column of the first and last pixel of the qualifying run
- `palm_width`  out  CW  end_c − start_c + 1
- `palm_height`  out  CW  derived height
- `palm_valid`  out  1  one-cycle pulse when results update
- `frame_done`  out  1  one-cycle pulse after the last pixel of the frame
- `palm_found`  out  1  level: a palm has been found in the current or last frame

## Operation
- Raster counters `row`/`col` advance only on accepted pixels (`pix_valid`). At `col == IMG_W-1`: `col` goes to 0 and `row` increments. At `row == IMG_H-1 && col == IMG_W-1`: both go to 0.
- Pixel accepted with `sof=1`:
  - counters forced to (0,0) for that pixel;
  - any open run is discarded;
  - `palm_found` is cleared;
  - FSM → SCAN.
- FSM states:
  - IDLE (after reset): waits for `sof`.
  - SCAN: run detection is active.
  - DONE: a palm was found; pixels are ignored except for counter tracking and `sof`.
- Run detection in SCAN:
  - An object pixel with no open run opens a run: `run_c` ← `col`, `run_r` ← `row`.
  - A run closes on the first background pixel; the last column is `col-1`.
  - A run also closes at the row end, including that pixel if it is an object pixel. Runs never span rows.
  - If closed width ≥ `MIN_RUN`, outputs are registered, `palm_valid` pulses, `palm_found` is set, and FSM → DONE.
  - A shorter run is discarded and scanning continues.
- Height = `palm_width + (palm_width >> 1)`, computed in CW+1 bits and saturated to 2^CW−1.
- With the macro defined and `test_mode=1`, height = `palm_height_test`, sampled on the qualifying cycle.
- Results hold until the next qualifying run or reset. They are not cleared at `sof`.

## Timing
- Reset: all outputs 0, `palm_found` 0, FSM IDLE, counters 0, no open run.
- Latency: results and `palm_valid` appear one cycle after the accepted pixel that closes the run.
- `frame_done` pulses one cycle after the pixel at (`IMG_H-1`,`IMG_W-1`) is accepted, in any state except IDLE. `palm_found` is valid on that cycle.
- Simultaneous run close and frame end: `palm_valid` and `frame_done` pulse on the same cycle.
- `sof` mid-frame: the frame restarts and no `frame_done` is issued for the aborted frame.
- `sof` in DONE: the block re-arms with that pixel evaluated in SCAN.
- `pix_valid=0`: no state changes. Gaps of any length are legal.
- Reset mid-frame: everything returns to reset values and the block waits for the next `sof`.

## Configuration
- `PALM_HEIGHT_OVERRIDE_EN` defined: ports `test_mode` and `palm_height_test` exist, and the override applies as described in Operation.
- Macro undefined: both ports are absent and height is always computed.

## Structure
- Package `palm_pkg`:
  - FSM state enum (IDLE/SCAN/DONE);
  - default `IMG_W`/`IMG_H`/`MIN_RUN` constants;
  - function `palm_height_calc(width)` with saturation.
- Sub-module `raster_counter`: `row`/`col` tracking with `sof` restart, `last_col` and `last_pix` flags.

## Test plan
- `sof`, then row 10 with object pixels at cols 30–59 (30 px), all other pixels background → one cycle after col 60: `palm_valid` pulses; start=(10,30), end=(10,59), width 30, height 45.
- Row 5 run at cols 0–9 (10 px), then row 7 run at cols 20–39 (20 px) → the row-5 run is ignored; result start=(7,20), width 20, height 30.
- Run at cols 100–119 of row 3 (ends at row edge) → end_c 119, width 20, `palm_valid` one cycle after col 119.
- Frame of all background → no `palm_valid`; `frame_done` pulses with `palm_found=0`.
- Macro defined, `test_mode=1`, `palm_height_test=77`, width-30 run → `palm_height=77`.
- Found in frame 1; `sof` at row 50 mid-frame 2 with a run at row 2, cols 0–19 → `palm_found` clears, then re-sets with start=(2,0); no `frame_done` for the aborted frame.

Source files
------------

// File: rtl/palm_pkg.sv
// Shared types, default geometry and the saturating palm-height helper for palm_locator.
package palm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } palm_state_e;

  localparam int IMG_W_DEF   = 120;
  localparam int IMG_H_DEF   = 160;
  localparam int MIN_RUN_DEF = 18;
  localparam int CW_DEF      = 8;

  // width * 1.5, saturated to the largest value representable in cw bits
  function automatic logic [15:0] palm_height_calc(input logic [15:0] width, input int unsigned cw);
    logic [16:0] w_sum;
    logic [16:0] w_max;
    w_sum = {1'b0, width} + {2'b00, width[15:1]};
    w_max = (17'd1 << cw) - 17'd1;
    if (w_sum > w_max) begin
      return w_max[15:0];
    end else begin
      return w_sum[15:0];
    end
  endfunction

endpackage

// File: rtl/palm_locator_raster_counter.sv
// Row/column tracker for the pixel raster; sof forces the current pixel to (0,0).
module raster_counter
  import palm_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last_pix
);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  // coordinates of the pixel currently presented
  always_comb begin
    if (sof) begin
      row = '0;
      col = '0;
    end else begin
      row = r_row;
      col = r_col;
    end
    last_col = (col == CW'(IMG_W - 1));
    last_pix = last_col && (row == CW'(IMG_H - 1));
  end

  // advance to the next raster position on every accepted pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (pix_valid) begin
      if (last_col) begin
        r_col <= '0;
        r_row <= last_pix ? '0 : row + CW'(1);
      end else begin
        r_col <= col + CW'(1);
        r_row <= row;
      end
    end
  end

endmodule

// File: rtl/palm_locator.sv
// Frame-aware palm locator: reports the first run of object pixels >= MIN_RUN per frame.
// Optional macro PALM_HEIGHT_OVERRIDE_EN adds test_mode/palm_height_test height override ports.
module palm_locator
  import palm_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int CW      = CW_DEF,
  parameter int MIN_RUN = MIN_RUN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic          pix,
  input  logic          sof,
`ifdef PALM_HEIGHT_OVERRIDE_EN
  input  logic          test_mode,
  input  logic [CW-1:0] palm_height_test,
`endif
  output logic [CW-1:0] start_r,
  output logic [CW-1:0] start_c,
  output logic [CW-1:0] end_r,
  output logic [CW-1:0] end_c,
  output logic [CW-1:0] palm_width,
  output logic [CW-1:0] palm_height,
  output logic          palm_valid,
  output logic          frame_done,
  output logic          palm_found
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_SCAN = 2'(ST_SCAN);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  logic [CW-1:0] w_row, w_col;
  logic          w_last_col, w_last_pix;

  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) u_raster (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .sof       (sof),
    .row       (w_row),
    .col       (w_col),
    .last_col  (w_last_col),
    .last_pix  (w_last_pix)
  );

  logic [1:0]    r_state;
  logic          r_run_open;
  logic [CW-1:0] r_run_c, r_run_r;

  logic          w_eval, w_open, w_close, w_qualify;
  logic [CW-1:0] w_start_c, w_start_r, w_end_c, w_height;
  logic [CW:0]   w_width;

  // run-close detection for the accepted pixel; sof discards any open run
  always_comb begin
    w_eval    = pix_valid && (sof || (r_state == S_SCAN));
    w_open    = r_run_open && !sof;
    w_start_c = w_open ? r_run_c : w_col;
    w_start_r = w_open ? r_run_r : w_row;
    if (pix) begin
      w_close = w_last_col;
      w_end_c = w_col;
    end else begin
      w_close = w_open;
      w_end_c = w_col - CW'(1);
    end
    w_width   = {1'b0, w_end_c} - {1'b0, w_start_c} + (CW+1)'(1);
    w_qualify = w_eval && w_close && (w_width >= (CW+1)'(MIN_RUN));
`ifdef PALM_HEIGHT_OVERRIDE_EN
    if (test_mode) begin
      w_height = palm_height_test;
    end else begin
      w_height = CW'(palm_height_calc(16'(w_width), CW));
    end
`else
    w_height = CW'(palm_height_calc(16'(w_width), CW));
`endif
  end

  // FSM, run tracking and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_run_open  <= 1'b0;
      r_run_c     <= '0;
      r_run_r     <= '0;
      start_r     <= '0;
      start_c     <= '0;
      end_r       <= '0;
      end_c       <= '0;
      palm_width  <= '0;
      palm_height <= '0;
      palm_valid  <= 1'b0;
      frame_done  <= 1'b0;
      palm_found  <= 1'b0;
    end else begin
      palm_valid <= w_qualify;
      frame_done <= pix_valid && w_last_pix && ((r_state != S_IDLE) || sof);
      if (pix_valid) begin
        if (w_qualify) begin
          r_state <= S_DONE;
        end else if (sof) begin
          r_state <= S_SCAN;
        end
        r_run_open <= w_eval && pix && !w_last_col;
        if (w_eval && pix && !w_open) begin
          r_run_c <= w_col;
          r_run_r <= w_row;
        end
        if (w_qualify) begin
          palm_found  <= 1'b1;
          start_r     <= w_start_r;
          start_c     <= w_start_c;
          end_r       <= w_row;
          end_c       <= w_end_c;
          palm_width  <= w_width[CW-1:0];
          palm_height <= w_height;
        end else if (sof) begin
          palm_found <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_palm_locator.sv
// Scoreboard bench for palm_locator: expected results queued at stimulus, checked when the DUT pulses.
module tb_palm_locator;

  localparam int W  = 120;
  localparam int H  = 56;
  localparam int CW = 8;
  localparam int MR = 18;

  logic          clk = 1'b0;
  logic          rst, pix_valid, pix, sof;
  logic [CW-1:0] start_r, start_c, end_r, end_c, palm_width, palm_height;
  logic          palm_valid, frame_done, palm_found;
`ifdef PALM_HEIGHT_OVERRIDE_EN
  logic          test_mode;
  logic [CW-1:0] palm_height_test;
`endif

  palm_locator #(.IMG_W(W), .IMG_H(H), .CW(CW), .MIN_RUN(MR)) dut (
    .clk              (clk),
    .rst              (rst),
    .pix_valid        (pix_valid),
    .pix              (pix),
    .sof              (sof),
`ifdef PALM_HEIGHT_OVERRIDE_EN
    .test_mode        (test_mode),
    .palm_height_test (palm_height_test),
`endif
    .start_r          (start_r),
    .start_c          (start_c),
    .end_r            (end_r),
    .end_c            (end_c),
    .palm_width       (palm_width),
    .palm_height      (palm_height),
    .palm_valid       (palm_valid),
    .frame_done       (frame_done),
    .palm_found       (palm_found)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] sr, sc, er, ec, w, h;
    int            cr, cc;
  } exp_t;
  typedef struct {
    int cyc;
    bit found;
  } fd_t;

  exp_t sb[$];
  fd_t  fdq[$];
  int   seg_r[$], seg_c0[$], seg_c1[$];
  int   cyc = 0;
  int   close_cyc = -1;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(int sr, int sc, int er, int ec, int w, int h, int cr, int cc);
    exp_t e;
    e.sr = CW'(sr); e.sc = CW'(sc); e.er = CW'(er); e.ec = CW'(ec);
    e.w = CW'(w); e.h = CW'(h); e.cr = cr; e.cc = cc;
    return e;
  endfunction

  function automatic bit is_obj(int r, int c);
    for (int i = 0; i < seg_r.size(); i++)
      if (seg_r[i] == r && c >= seg_c0[i] && c <= seg_c1[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_seg(int r, int c0, int c1);
    seg_r.push_back(r); seg_c0.push_back(c0); seg_c1.push_back(c1);
  endtask

  task automatic clear_segs();
    seg_r.delete(); seg_c0.delete(); seg_c1.delete();
  endtask

  // scoreboard monitor: pops an expectation whenever the DUT pulses
  always @(negedge clk) begin
    exp_t e;
    fd_t  f;
    if (palm_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL palm_valid_unexpected cycle=%0d start=(%0d,%0d) width=%0d", cyc, start_r, start_c, palm_width);
      end else begin
        e = sb.pop_front();
        if (start_r !== e.sr || start_c !== e.sc || end_r !== e.er || end_c !== e.ec ||
            palm_width !== e.w || palm_height !== e.h || cyc != close_cyc)
          $display("FAIL palm_result got s=(%0d,%0d) e=(%0d,%0d) w=%0d h=%0d cyc=%0d expected s=(%0d,%0d) e=(%0d,%0d) w=%0d h=%0d cyc=%0d",
                   start_r, start_c, end_r, end_c, palm_width, palm_height, cyc,
                   e.sr, e.sc, e.er, e.ec, e.w, e.h, close_cyc);
        else n_pass++;
      end
    end
    if (frame_done === 1'b1) begin
      n_checks++;
      if (fdq.size() == 0) begin
        $display("FAIL frame_done_unexpected cycle=%0d", cyc);
      end else begin
        f = fdq.pop_front();
        if (cyc != f.cyc || palm_found !== f.found)
          $display("FAIL frame_done got cyc=%0d found=%b expected cyc=%0d found=%b", cyc, palm_found, f.cyc, f.found);
        else n_pass++;
      end
    end
  end

  task automatic send_pixel(int r, int c, bit s, bit gaps, bit exp_found);
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix       = 1'b1;
    end
    @(negedge clk);
    pix_valid = 1'b1;
    pix       = is_obj(r, c);
    sof       = s;
    if (sb.size() > 0 && sb[0].cr == r && sb[0].cc == c) close_cyc = cyc + 1;
    if (s && r == H - 1 && c == W - 1) begin
      fd_t f;
      f.cyc = cyc + 1; f.found = exp_found;
      fdq.push_back(f);
    end
  endtask

  // npix pixels of a frame starting with sof; a complete frame expects frame_done
  task automatic send_frame(int npix, bit exp_found, bit gaps);
    for (int k = 0; k < npix; k++) begin
      send_pixel(k / W, k % W, (k == 0), gaps, exp_found);
      if (k == W * H - 1) begin
        fd_t f;
        f.cyc = cyc + 1; f.found = exp_found;
        fdq.push_back(f);
      end
    end
    @(negedge clk);
    pix_valid = 1'b0; pix = 1'b0; sof = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_drained(string name);
    n_checks++;
    if (sb.size() != 0 || fdq.size() != 0)
      $display("FAIL %s pending results=%0d frame_done=%0d expected 0/0", name, sb.size(), fdq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({start_r, start_c, end_r, end_c, palm_width, palm_height} !== '0 ||
        palm_valid !== 1'b0 || frame_done !== 1'b0 || palm_found !== 1'b0)
      $display("FAIL reset_state got s=(%0d,%0d) w=%0d h=%0d pv=%b fd=%b pf=%b expected all 0",
               start_r, start_c, palm_width, palm_height, palm_valid, frame_done, palm_found);
    else n_pass++;
  endtask

  task automatic test_basic();
    clear_segs();
    add_seg(10, 30, 59);
    add_seg(20, 0, 40);
    sb.push_back(mk(10, 30, 10, 59, 30, 45, 10, 60));
    send_frame(W * H, 1'b1, 1'b1);
    check_drained("basic");
  endtask

  task automatic test_short_then_long();
    clear_segs();
    add_seg(5, 0, 9);
    add_seg(7, 20, 39);
    sb.push_back(mk(7, 20, 7, 39, 20, 30, 7, 40));
    send_frame(W * H, 1'b1, 1'b0);
    check_drained("short_then_long");
  endtask

  task automatic test_row_edge();
    clear_segs();
    add_seg(3, 100, 119);
    add_seg(4, 0, 30);
    sb.push_back(mk(3, 100, 3, 119, 20, 30, 3, 119));
    send_frame(W * H, 1'b1, 1'b0);
    check_drained("row_edge");
  endtask

  task automatic test_empty_frame();
    clear_segs();
    send_frame(W * H, 1'b0, 1'b0);
    check_drained("empty_frame");
    n_checks++;
    if (palm_width !== 8'd20 || end_c !== 8'd119 || palm_found !== 1'b0)
      $display("FAIL empty_hold got w=%0d end_c=%0d found=%b expected w=20 end_c=119 found=0", palm_width, end_c, palm_found);
    else n_pass++;
  endtask

  task automatic test_min_run();
    clear_segs();
    add_seg(1, 0, 16);
    add_seg(2, 50, 67);
    sb.push_back(mk(2, 50, 2, 67, 18, 27, 2, 68));
    send_frame(W * H, 1'b1, 1'b0);
    check_drained("min_run");
  endtask

  task automatic test_back_to_back();
    clear_segs();
    add_seg(H - 1, 102, 119);
    sb.push_back(mk(H - 1, 102, H - 1, 119, 18, 27, H - 1, 119));
    send_frame(W * H, 1'b1, 1'b0);
    check_drained("back_to_back");
  endtask

  task automatic test_sof_restart();
    clear_segs();
    add_seg(10, 30, 59);
    sb.push_back(mk(10, 30, 10, 59, 30, 45, 10, 60));
    send_frame(W * H, 1'b1, 1'b0);
    clear_segs();
    send_frame(50 * W, 1'b0, 1'b0);
    n_checks++;
    if (palm_found !== 1'b0 || start_r !== 8'd10)
      $display("FAIL restart_clear got found=%b start_r=%0d expected found=0 start_r=10", palm_found, start_r);
    else n_pass++;
    add_seg(2, 0, 19);
    sb.push_back(mk(2, 0, 2, 19, 20, 30, 2, 20));
    send_frame(W * H, 1'b1, 1'b0);
    check_drained("sof_restart");
    n_checks++;
    if (palm_found !== 1'b1)
      $display("FAIL restart_found got %b expected 1", palm_found);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    clear_segs();
    add_seg(4, 0, 29);
    send_frame(4 * W + 11, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (palm_width !== '0 || start_r !== '0 || palm_found !== 1'b0)
      $display("FAIL mid_reset got w=%0d start_r=%0d found=%b expected 0/0/0", palm_width, start_r, palm_found);
    else n_pass++;
    for (int k = 0; k < 2 * W; k++) send_pixel(4 + k / W, k % W, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    pix_valid = 1'b0; pix = 1'b0;
    repeat (3) @(negedge clk);
    check_drained("idle_ignores");
  endtask

`ifdef PALM_HEIGHT_OVERRIDE_EN
  task automatic test_override();
    clear_segs();
    add_seg(10, 30, 59);
    test_mode = 1'b1;
    palm_height_test = 8'd77;
    sb.push_back(mk(10, 30, 10, 59, 30, 77, 10, 60));
    send_frame(W * H, 1'b1, 1'b0);
    test_mode = 1'b0;
    check_drained("override");
  endtask
`endif

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix = 1'b0; sof = 1'b0;
`ifdef PALM_HEIGHT_OVERRIDE_EN
    test_mode = 1'b0;
    palm_height_test = '0;
`endif
    test_reset();
    test_basic();
    test_short_then_long();
    test_row_edge();
    test_empty_frame();
    test_min_run();
    test_back_to_back();
`ifdef PALM_HEIGHT_OVERRIDE_EN
    test_override();
`endif
    test_sof_restart();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
